// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: result-select codes, load funct3 values, FSM state.
// Also holds the load-size/signedness decode used by the lane aligner.
package wb_pkg;

    localparam logic [1:0] WB_SEL_PC4 = 2'd0;
    localparam logic [1:0] WB_SEL_ALU = 2'd1;
    localparam logic [1:0] WB_SEL_IMM = 2'd2;
    localparam logic [1:0] WB_SEL_MEM = 2'd3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } wb_state_t;

    // log2 of the access size in bytes; 111 and (on RV32) LD collapse onto a word
    function automatic logic [1:0] load_size(input logic [2:0] funct3, input int xlen);
        logic [1:0] sz;
        sz = funct3[1:0];
        if (funct3 == 3'b111) sz = 2'd2;
        if (xlen == 32 && sz == 2'd3) sz = 2'd2;
        return sz;
    endfunction

    function automatic logic load_signed(input logic [2:0] funct3);
        return (funct3[2] == 1'b0) || (funct3 == 3'b111);
    endfunction

endpackage

// File: rtl/wb_load_align.sv
// Load lane extraction: picks the byte/half/word/dword at addr_lo and sign/zero-extends it.
// Purely combinational, no latency, no flow control; misalign flag only with WB_MISALIGN_CHECK_EN.
// Without the check, offset bits below the access size are ignored (containing aligned unit).
module wb_load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OW   = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      funct3,
    input  logic [OW-1:0]   addr_lo,
    output logic [XLEN-1:0] data
`ifdef WB_MISALIGN_CHECK_EN
    ,
    output logic            misalign
`endif
);

    logic [1:0]      sz;
    logic            sgn;
    logic            sbit;
    logic [OW-1:0]   lo_mask;
    logic [OW-1:0]   off;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] keep_mask;

    always_comb begin
        sz      = load_size(funct3, XLEN);
        sgn     = load_signed(funct3);
        // a shift that overflows OW bits yields 0, so the mask becomes all-ones for full-width units
        lo_mask = (OW'(1) << sz) - OW'(1);
        off     = addr_lo & ~lo_mask;
        shifted = rdata >> {off, 3'b000};
        case (sz)
            2'd0:    begin keep_mask = XLEN'(8'hFF);         sbit = shifted[7];  end
            2'd1:    begin keep_mask = XLEN'(16'hFFFF);      sbit = shifted[15]; end
            2'd2:    begin keep_mask = XLEN'(32'hFFFF_FFFF); sbit = shifted[31]; end
            default: begin keep_mask = '1;                   sbit = 1'b0;        end
        endcase
        data = shifted & keep_mask;
        if (sgn && sbit) data = data | ~keep_mask;
`ifdef WB_MISALIGN_CHECK_EN
        misalign = |(addr_lo & lo_mask);
`endif
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: selects PC+4/ALU/IMM/load data and issues a one-cycle register-file write.
// Latency: non-load 1 cycle after accept; load 1 cycle after the response edge.
// Backpressure: ready_o low while a load waits for its response or flush; optional WB_MISALIGN_CHECK_EN.
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [1:0]                sel_i,
    input  logic [XLEN-1:0]           pc_plus4_i,
    input  logic [XLEN-1:0]           alu_result_i,
    input  logic [XLEN-1:0]           imm_i,
    input  logic [REG_AW-1:0]         rd_i,
    input  logic                      rd_we_i,
    input  logic [2:0]                funct3_i,
    input  logic [$clog2(XLEN/8)-1:0] addr_lo_i,
    input  logic                      mem_rvalid_i,
    input  logic [XLEN-1:0]           mem_rdata_i,
    input  logic                      flush_i,
    output logic                      rf_we_o,
    output logic [REG_AW-1:0]         rf_waddr_o,
    output logic [XLEN-1:0]           rf_wdata_o
`ifdef WB_MISALIGN_CHECK_EN
    ,
    output logic                      misalign_o
`endif
);

    localparam int OW = $clog2(XLEN / 8);

    wb_state_t         state_q, state_d;
    logic              accept;
    logic              wb_now;
    logic              ld_start;
    logic              ld_done;
    logic [XLEN-1:0]   sel_data;
    logic [XLEN-1:0]   ld_data;
    logic [REG_AW-1:0] ld_rd_q;
    logic              ld_we_q;
    logic [2:0]        ld_f3_q;
    logic [OW-1:0]     ld_off_q;
`ifdef WB_MISALIGN_CHECK_EN
    logic              ld_mis;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (valid_i && sel_i == WB_SEL_MEM) state_d = ST_WAIT_MEM;
            ST_WAIT_MEM: if (flush_i || mem_rvalid_i)         state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_o  = (state_q == ST_IDLE);
        accept   = ready_o && valid_i;
        wb_now   = accept && (sel_i != WB_SEL_MEM);
        ld_start = accept && (sel_i == WB_SEL_MEM);
        // flush beats a same-cycle response; the response is simply dropped
        ld_done  = (state_q == ST_WAIT_MEM) && mem_rvalid_i && !flush_i;
        case (sel_i)
            WB_SEL_PC4: sel_data = pc_plus4_i;
            WB_SEL_ALU: sel_data = alu_result_i;
            WB_SEL_IMM: sel_data = imm_i;
            default:    sel_data = '0;
        endcase
    end

    wb_load_align #(
        .XLEN (XLEN),
        .OW   (OW)
    ) u_align (
        .rdata    (mem_rdata_i),
        .funct3   (ld_f3_q),
        .addr_lo  (ld_off_q),
        .data     (ld_data)
`ifdef WB_MISALIGN_CHECK_EN
        ,
        .misalign (ld_mis)
`endif
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ld_rd_q  <= '0;
            ld_we_q  <= 1'b0;
            ld_f3_q  <= '0;
            ld_off_q <= '0;
        end else if (ld_start) begin
            ld_rd_q  <= rd_i;
            ld_we_q  <= rd_we_i && (rd_i != '0);
            ld_f3_q  <= funct3_i;
            ld_off_q <= addr_lo_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
`ifdef WB_MISALIGN_CHECK_EN
            misalign_o <= 1'b0;
`endif
        end else begin
            rf_we_o <= 1'b0;
`ifdef WB_MISALIGN_CHECK_EN
            misalign_o <= 1'b0;
`endif
            if (wb_now) begin
                rf_we_o    <= rd_we_i && (rd_i != '0);
                rf_waddr_o <= rd_i;
                rf_wdata_o <= sel_data;
            end else if (ld_done) begin
                rf_waddr_o <= ld_rd_q;
                rf_wdata_o <= ld_data;
`ifdef WB_MISALIGN_CHECK_EN
                rf_we_o    <= ld_we_q && !ld_mis;
                misalign_o <= ld_mis;
`else
                rf_we_o    <= ld_we_q;
`endif
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage (XLEN=32): directed cases followed by randomized traffic
// compared against an arithmetic reference model of load extraction and write enables.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic        ready;
    logic [1:0]  sel;
    logic [31:0] pc4, alu, imm;
    logic [4:0]  rd;
    logic        rd_we;
    logic [2:0]  f3;
    logic [1:0]  addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        flush;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
`ifdef WB_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .valid_i      (valid),
        .ready_o      (ready),
        .sel_i        (sel),
        .pc_plus4_i   (pc4),
        .alu_result_i (alu),
        .imm_i        (imm),
        .rd_i         (rd),
        .rd_we_i      (rd_we),
        .funct3_i     (f3),
        .addr_lo_i    (addr_lo),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .flush_i      (flush),
        .rf_we_o      (rf_we),
        .rf_waddr_o   (waddr),
        .rf_wdata_o   (wdata)
`ifdef WB_MISALIGN_CHECK_EN
        ,
        .misalign_o   (misalign)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // access size in bytes on RV32: 1, 2 or 4 (dword and 111 fold onto word)
    function automatic int ref_bytes(input logic [2:0] f);
        int n;
        n = 1 << f[1:0];
        if (n > 4) n = 4;
        return n;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f, input int off);
        int              n, base;
        bit              sgn;
        longint unsigned v;
        n    = ref_bytes(f);
        sgn  = (f[2] == 1'b0) || (f == 3'b111);
        base = (off / n) * n;
        v    = w;
        v    = (v >> (8 * base)) % (64'd1 << (8 * n));
        if (sgn && n < 4 && v >= (64'd1 << (8 * n - 1)))
            v = v + 64'h1_0000_0000 - (64'd1 << (8 * n));
        return v[31:0];
    endfunction

    function automatic bit ref_mis(input logic [2:0] f, input int off);
`ifdef WB_MISALIGN_CHECK_EN
        return (off % ref_bytes(f)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic issue_nonload(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input logic [4:0] r, input logic w);
        logic [31:0] exp;
        valid = 1'b1; sel = s; pc4 = a; alu = b; imm = c; rd = r; rd_we = w;
        f3 = 3'($urandom_range(0, 7)); addr_lo = 2'($urandom_range(0, 3));
        cyc();
        valid = 1'b0;
        exp = (s == 2'd0) ? a : (s == 2'd1) ? b : c;
        chk("nl_we",    rf_we, w && (r != 0));
        chk("nl_waddr", waddr, r);
        chk("nl_wdata", wdata, exp);
        chk("nl_rdy",   ready, 1'b1);
    endtask

    task automatic do_load(input logic [4:0] r, input logic w, input logic [2:0] fv, input int off,
                           input logic [31:0] data, input int waits, input bit do_flush);
        bit mis;
        valid = 1'b1; sel = 2'd3; rd = r; rd_we = w; f3 = fv; addr_lo = 2'(off);
        cyc();
        valid = 1'b0;
        f3 = 3'($urandom_range(0, 7)); addr_lo = 2'($urandom_range(0, 3)); rd = 5'($urandom);
        for (int i = 0; i < waits; i++) begin
            chk("ld_stall_rdy", ready, 1'b0);
            chk("ld_stall_we",  rf_we, 1'b0);
            if (i == waits - 1) begin
                mem_rvalid = 1'b1; mem_rdata = data; flush = do_flush;
            end
            cyc();
        end
        mem_rvalid = 1'b0; flush = 1'b0; mem_rdata = $urandom;
        chk("ld_rdy_after", ready, 1'b1);
        if (do_flush) begin
            chk("flush_we", rf_we, 1'b0);
        end else begin
            mis = ref_mis(fv, off);
            chk("ld_we",    rf_we, w && (r != 0) && !mis);
            chk("ld_waddr", waddr, r);
            if (!mis) chk("ld_wdata", wdata, ref_load(data, fv, off));
`ifdef WB_MISALIGN_CHECK_EN
            chk("ld_misalign", misalign, mis);
`endif
        end
        cyc();
        chk("ld_we_pulse", rf_we, 1'b0);
`ifdef WB_MISALIGN_CHECK_EN
        chk("ld_mis_pulse", misalign, 1'b0);
`endif
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; sel = '0; pc4 = '0; alu = '0; imm = '0; rd = '0; rd_we = 1'b0;
        f3 = '0; addr_lo = '0; mem_rvalid = 1'b0; mem_rdata = '0; flush = 1'b0;
        @(negedge clk);
        chk("rst_rdy",   ready, 1'b1);
        chk("rst_we",    rf_we, 1'b0);
        chk("rst_waddr", waddr, 5'd0);
        chk("rst_wdata", wdata, 32'd0);
`ifdef WB_MISALIGN_CHECK_EN
        chk("rst_mis", misalign, 1'b0);
`endif
        cyc();
        rst_n = 1'b1;
        cyc();

        issue_nonload(2'd1, 32'h0000_1004, 32'h1234_5678, 32'h0000_0099, 5'd5, 1'b1);
        cyc();
        chk("alu_we_drop", rf_we, 1'b0);

        do_load(5'd6, 1'b1, 3'b000, 3, 32'h80FF_0000, 3, 1'b0);
        do_load(5'd7, 1'b1, 3'b101, 2, 32'hBEEF_1234, 1, 1'b0);
        do_load(5'd8, 1'b1, 3'b001, 2, 32'hBEEF_1234, 2, 1'b0);

        issue_nonload(2'd2, 32'h1, 32'h2, 32'h0000_0007, 5'd0, 1'b1);
        do_load(5'd0, 1'b1, 3'b010, 0, 32'hCAFE_F00D, 2, 1'b0);

        do_load(5'd9, 1'b1, 3'b010, 0, 32'h1111_2222, 2, 1'b1);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        cyc();
        mem_rvalid = 1'b0;
        chk("stray_we",  rf_we, 1'b0);
        chk("stray_rdy", ready, 1'b1);

        do_load(5'd3, 1'b1, 3'b010, 1, 32'h89AB_CDEF, 1, 1'b0);
        do_load(5'd4, 1'b1, 3'b100, 1, 32'h0000_8000, 1, 1'b0);
        issue_nonload(2'd0, 32'h0000_2008, 32'h2, 32'h3, 5'd12, 1'b1);
        issue_nonload(2'd1, 32'h1, 32'hFFFF_0000, 32'h3, 5'd13, 1'b0);

        for (int t = 0; t < 150; t++) begin
            logic [4:0] r;
            r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            if ($urandom_range(0, 2) == 0)
                issue_nonload(2'($urandom_range(0, 2)), $urandom, $urandom, $urandom, r, 1'($urandom));
            else
                do_load(r, 1'($urandom), 3'($urandom_range(0, 7)), int'($urandom_range(0, 3)), $urandom,
                        int'($urandom_range(1, 4)), $urandom_range(0, 7) == 0);
        end

        issue_nonload(2'd1, 32'h1, 32'h0000_A5A5, 32'h3, 5'd7, 1'b1);
        valid = 1'b1; sel = 2'd3; rd = 5'd9; rd_we = 1'b1; f3 = 3'b010; addr_lo = 2'd0;
        cyc();
        valid = 1'b0;
        chk("pre_rst_rdy", ready, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rdy",   ready, 1'b1);
        chk("arst_we",    rf_we, 1'b0);
        chk("arst_waddr", waddr, 5'd0);
        chk("arst_wdata", wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        cyc();
        mem_rvalid = 1'b0;
        chk("arst_lost_we",  rf_we, 1'b0);
        chk("arst_lost_rdy", ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Registered, parametrised writeback stage of the RISC-V core. Selects the result among PC+4, ALU result, immediate, and load data; writes it to the register file one cycle after acceptance. Loads are waited on: the stage stalls upstream until the memory response arrives, then aligns and sign/zero-extends the data. Sits between the MEM stage / data-memory port and the register-file write port.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- REG_AW, 5, register-file address width.
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- valid_i  in  1  upstream instruction valid.
- ready_o  out  1  stage can accept; high exactly when state is IDLE.
- sel_i  in  2  source: 0 PC+4, 1 ALU, 2 IMM, 3 MEM.
- pc_plus4_i / alu_result_i / imm_i  in  XLEN each  candidate results.
- rd_i  in  REG_AW  destination register.
- rd_we_i  in  1  instruction writes rd.
- funct3_i  in  3  load type, used only when sel_i=3.
- addr_lo_i  in  log2(XLEN/8)  load byte offset.
- mem_rvalid_i  in  1  load response valid.
- mem_rdata_i  in  XLEN  load response data, naturally aligned word/dword.
- flush_i  in  1  discard the pending load.
- rf_we_o  out  1  register-file write strobe.
- rf_waddr_o  out  REG_AW  write address.
- rf_wdata_o  out  XLEN  write data.
- misalign_o  out  1  present only with WB_MISALIGN_CHECK_EN.

## Operation
- States: IDLE, WAIT_MEM.
- IDLE, valid_i=1, sel_i in 0..2: register the selected value, rd_i, and rd_we_i&&(rd_i!=0). Stay IDLE.
- IDLE, valid_i=1, sel_i=3: latch rd, the write enable, funct3, and addr_lo. Go to WAIT_MEM. mem_rvalid_i is ignored in IDLE.
- WAIT_MEM, mem_rvalid_i=1: extract from the lane selected by addr_lo. Register the result with the latched rd/enable. Go to IDLE.
- Load extraction:
  - LB 000, LBU 100: byte.
  - LH 001, LHU 101: halfword.
  - LW 010, LWU 110: word.
  - LD 011: dword.
  - Signed types sign-extend to XLEN; unsigned types zero-extend.
  - XLEN=32: LD and LWU behave as LW. funct3 111 behaves as LW.
- WAIT_MEM, flush_i=1: return to IDLE, no write. flush_i together with mem_rvalid_i: flush wins, and the response is dropped.
- Writes to x0 are never issued: rf_we_o stays 0 and rf_waddr_o/rf_wdata_o still update.

## Timing
- Reset values: state IDLE, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, misalign_o=0, latched load fields 0. ready_o=1 while in reset.
- Non-load latency: accept at edge N, rf_we_o high for cycle N+1 only.
- Load latency: mem_rvalid_i sampled at edge M (M ≥ N+1), rf_we_o high for cycle M+1.
- rf_we_o is a single-cycle pulse per instruction, never held.
- ready_o is combinational from state: low from N+1 until the edge that consumes the response or flush.
- Reset asserted mid-WAIT_MEM: immediate return to IDLE, outputs to reset values, pending load lost.

## Configuration
- WB_MISALIGN_CHECK_EN defined: misaligned halfword/word/dword loads suppress the write. misalign_o pulses in the cycle the write would have occurred.
  - Misaligned halfword: addr_lo[0]=1.
  - Misaligned word: addr_lo[1:0]≠0.
  - Misaligned dword: addr_lo≠0.
- Undefined: no misalign_o port. Offset low bits below the access size are ignored, and the containing aligned unit is extracted.

## Structure
- Package wb_pkg holds:
  - WB_SEL_PC4/ALU/IMM/MEM encodings.
  - F3_LB..F3_LWU load-type constants.
  - wb_state_t enum.
- Sub-module wb_load_align: purely combinational; inputs rdata, funct3, addr_lo; output extended data, plus a misalign flag under the macro.

## Test plan
- Reset, then accept sel=1, alu=32'h1234_5678, rd=5 → next cycle rf_we_o=1, waddr=5, wdata=32'h1234_5678. Following cycle rf_we_o=0.
- sel=3, LB, addr_lo=3, rdata=32'h80FF_0000 after 3-cycle wait → ready_o low 3 cycles, then wdata=32'hFFFF_FF80.
- LHU, addr_lo=2, rdata=32'hBEEF_1234 → wdata=32'h0000_BEEF. LH with the same inputs → 32'hFFFF_BEEF.
- rd=0, sel=2, imm=7 → rf_we_o stays 0. Load to rd=0 still stalls until the response.
- Load pending, flush_i and mem_rvalid_i in the same cycle → no write, ready_o=1 next cycle. A later stray mem_rvalid_i is ignored.
- WB_MISALIGN_CHECK_EN: LW, addr_lo=1 → rf_we_o=0, misalign_o=1 for one cycle. Without the macro: wdata=rdata.
